// File: rtl/drain_collector_if.sv
// Drain collector stream bundle: per-PE drain channels in, FIFO result stream out.
// slave = collector side, master = PE array / consumer side.
interface drain_collector_if #(
  parameter int NUM_PE     = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int IDX_W = $clog2(NUM_PE);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  enable;
  } drain_data_t;

  drain_data_t [NUM_PE-1:0] drain_i;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic [DATA_WIDTH-1:0]    out_data_o;
  logic [IDX_W-1:0]         out_idx_o;

  modport master (
    output drain_i, out_ready_i,
    input  out_valid_o, out_data_o, out_idx_o
  );

  modport slave (
    input  drain_i, out_ready_i,
    output out_valid_o, out_data_o, out_idx_o
  );
endinterface

// File: rtl/drain_collector.sv
// Drain collector: per-PE holding registers, round-robin arbiter, result FIFO.
// Optional sticky overflow flag enabled by defining DRAIN_OVERFLOW_DETECT_EN.
module drain_collector #(
  parameter int NUM_PE     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  drain_collector_if.slave                 bus,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  count_o,
  input  logic                             ovf_clr_i,
  output logic                             overflow_o
);
  localparam int IDX_W = $clog2(NUM_PE);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  logic [NUM_PE-1:0]     pending_q, pending_d;
  logic [DATA_WIDTH-1:0] hold_q [NUM_PE];
  logic [DATA_WIDTH-1:0] hold_d [NUM_PE];
  logic [IDX_W-1:0]      rrPtr_q, rrPtr_d;

  logic [DATA_WIDTH-1:0] memData_q [FIFO_DEPTH];
  logic [IDX_W-1:0]      memIdx_q  [FIFO_DEPTH];
  logic [PTR_W-1:0]      wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0]      count_q;

  logic              full, valid, push, pop, anyPending;
  logic [IDX_W-1:0]  grantIdx;
  logic [NUM_PE-1:0] ovfEvent;
  int                cand;

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign valid = (count_q != '0);
  assign pop   = valid && bus.out_ready_i;
  assign push  = anyPending && !full;

  // First pending channel at or after rrPtr_q, wrapping.
  always_comb begin
    anyPending = 1'b0;
    grantIdx   = '0;
    cand       = 0;
    for (int i = 0; i < NUM_PE; i++) begin
      cand = (int'(rrPtr_q) + i) % NUM_PE;
      if (!anyPending && pending_q[cand]) begin
        anyPending = 1'b1;
        grantIdx   = IDX_W'(cand);
      end
    end
  end

  // A channel granted this cycle may reload; otherwise a busy channel drops the new value.
  always_comb begin
    pending_d = pending_q;
    hold_d    = hold_q;
    ovfEvent  = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      if (bus.drain_i[k].enable) begin
        if (!pending_q[k] || (push && grantIdx == IDX_W'(k))) begin
          pending_d[k] = 1'b1;
          hold_d[k]    = bus.drain_i[k].data;
        end else begin
          ovfEvent[k] = 1'b1;
        end
      end else if (push && grantIdx == IDX_W'(k)) begin
        pending_d[k] = 1'b0;
      end
    end
  end

  always_comb begin
    rrPtr_d = rrPtr_q;
    if (push) begin
      rrPtr_d = (grantIdx == IDX_W'(NUM_PE-1)) ? '0 : grantIdx + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pending_q <= '0;
      rrPtr_q   <= '0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      for (int k = 0; k < NUM_PE; k++) hold_q[k] <= '0;
    end else begin
      pending_q <= pending_d;
      hold_q    <= hold_d;
      rrPtr_q   <= rrPtr_d;
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      memData_q[wrPtr_q] <= hold_q[grantIdx];
      memIdx_q[wrPtr_q]  <= grantIdx;
    end
  end

  assign bus.out_valid_o = valid;
  assign bus.out_data_o  = valid ? memData_q[rdPtr_q] : '0;
  assign bus.out_idx_o   = valid ? memIdx_q[rdPtr_q]  : '0;
  assign count_o         = count_q;

`ifdef DRAIN_OVERFLOW_DETECT_EN
  logic ovf_q, ovf_d;

  assign ovf_d = (|ovfEvent) ? 1'b1 : (ovf_clr_i ? 1'b0 : ovf_q);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign overflow_o = ovf_q;
`else
  logic unusedOvf;
  assign unusedOvf  = ovf_clr_i ^ (|ovfEvent);
  assign overflow_o = 1'b0;
`endif
endmodule

// File: tb/tb_drain_collector.sv
// Directed bench for drain_collector (NUM_PE=4, FIFO_DEPTH=8); overflow expectations
// follow DRAIN_OVERFLOW_DETECT_EN.
module tb_drain_collector;
  localparam int NUM_PE     = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int DATA_WIDTH = 32;
`ifdef DRAIN_OVERFLOW_DETECT_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic       clk_i;
  logic       rst_i;
  logic [3:0] count_o;
  logic       ovf_clr_i;
  logic       overflow_o;
  int         vectors;
  int         miscompares;

  drain_collector_if #(.NUM_PE(NUM_PE), .DATA_WIDTH(DATA_WIDTH)) bus ();

  drain_collector #(
    .NUM_PE(NUM_PE), .FIFO_DEPTH(FIFO_DEPTH), .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus), .count_o(count_o),
    .ovf_clr_i(ovf_clr_i), .overflow_o(overflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse(input int k, input logic [31:0] d);
    bus.drain_i[k].data   = d;
    bus.drain_i[k].enable = 1'b1;
  endtask

  // One clock with the staged pulses applied, then all enables dropped.
  task automatic applyStimulus();
    tick();
    for (int k = 0; k < NUM_PE; k++) bus.drain_i[k].enable = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkHead(input string tag, input logic [31:0] d, input logic [31:0] idx);
    checkOutput({tag, "_valid"}, bus.out_valid_o, 1);
    checkOutput({tag, "_data"}, bus.out_data_o, d);
    checkOutput({tag, "_idx"}, bus.out_idx_o, idx);
  endtask

  initial begin
    logic [31:0] expData;
    logic [31:0] expCnt;
    vectors     = 0;
    miscompares = 0;
    rst_i       = 1'b0;
    ovf_clr_i   = 1'b0;
    bus.out_ready_i = 1'b0;
    for (int k = 0; k < NUM_PE; k++) bus.drain_i[k] = '0;
    tick();
    tick();
    checkOutput("rst_valid", bus.out_valid_o, 0);
    checkOutput("rst_data", bus.out_data_o, 0);
    checkOutput("rst_idx", bus.out_idx_o, 0);
    checkOutput("rst_count", count_o, 0);
    checkOutput("rst_ovf", overflow_o, 0);
    rst_i = 1'b1;
    tick();

    // All four channels at once from rrPtr 0.
    bus.out_ready_i = 1'b1;
    for (int k = 0; k < NUM_PE; k++) pulse(k, 32'd10 + 32'(k));
    applyStimulus();
    checkOutput("sim_lat", bus.out_valid_o, 0);
    for (int k = 0; k < NUM_PE; k++) begin
      tick();
      checkHead($sformatf("sim%0d", k), 32'd10 + 32'(k), 32'(k));
      checkOutput($sformatf("sim%0d_cnt", k), count_o, 1);
    end
    tick();
    checkOutput("sim_empty", bus.out_valid_o, 0);

    // Single pulse on channel 2.
    pulse(2, 32'h0000_00A5);
    applyStimulus();
    checkOutput("one_lat", bus.out_valid_o, 0);
    tick();
    checkHead("one", 32'hA5, 2);
    tick();
    checkOutput("one_gone", bus.out_valid_o, 0);

    // rrPtr now 3: order 3,0,1,2.
    for (int k = 0; k < NUM_PE; k++) pulse(k, 32'd20 + 32'(k));
    applyStimulus();
    for (int j = 0; j < NUM_PE; j++) begin
      tick();
      checkHead($sformatf("rr%0d", j), 32'd20 + 32'((j + 3) % 4), 32'((j + 3) % 4));
    end
    tick();
    checkOutput("rr_empty", bus.out_valid_o, 0);

    // Reload of a channel in its grant cycle is captured, not dropped.
    bus.out_ready_i = 1'b0;
    pulse(1, 32'h30);
    applyStimulus();
    pulse(1, 32'h31);
    applyStimulus();
    checkHead("rel_a", 32'h30, 1);
    checkOutput("rel_cnt1", count_o, 1);
    tick();
    checkHead("rel_hold", 32'h30, 1);
    checkOutput("rel_cnt2", count_o, 2);
    checkOutput("rel_ovf", overflow_o, 0);
    bus.out_ready_i = 1'b1;
    tick();
    checkHead("rel_b", 32'h31, 1);
    checkOutput("rel_cnt3", count_o, 1);
    tick();
    checkOutput("rel_empty", bus.out_valid_o, 0);

    // Backpressure: nine staggered pulses, FIFO saturates with one left pending.
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      pulse(i % 4, 32'h100 + 32'(i));
      applyStimulus();
    end
    tick();
    checkOutput("bp_count", count_o, 8);
    checkHead("bp_head", 32'h100, 0);

    // Overflow while full: second value on channel 1 is lost.
    pulse(1, 32'h200);
    applyStimulus();
    checkOutput("ovf_none", overflow_o, 0);
    pulse(1, 32'h201);
    applyStimulus();
    checkOutput("ovf_set", overflow_o, 32'(OVF_EN));
    tick();
    checkOutput("ovf_sticky", overflow_o, 32'(OVF_EN));
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    checkOutput("ovf_clr", overflow_o, 0);
    checkOutput("ovf_count", count_o, 8);

    // Drain: eight FIFO entries, then channel 0 and channel 1 holding values.
    bus.out_ready_i = 1'b1;
    for (int j = 0; j < 10; j++) begin
      expData = (j < 8) ? 32'h100 + 32'(j) : ((j == 8) ? 32'h108 : 32'h200);
      expCnt  = (j == 0) ? 8 : ((j <= 3) ? 7 : 32'(10 - j));
      checkHead($sformatf("drn%0d", j), expData, (j < 9) ? 32'(j % 4) : 1);
      checkOutput($sformatf("drn%0d_cnt", j), count_o, expCnt);
      tick();
    end
    checkOutput("drn_empty", bus.out_valid_o, 0);
    checkOutput("drn_cnt", count_o, 0);

    // Reset mid-stream with three entries buffered.
    bus.out_ready_i = 1'b0;
    pulse(0, 32'h300);
    pulse(1, 32'h301);
    pulse(2, 32'h302);
    applyStimulus();
    tick();
    tick();
    tick();
    checkOutput("mid_count", count_o, 3);
    rst_i = 1'b0;
    #1;
    checkOutput("mid_valid", bus.out_valid_o, 0);
    checkOutput("mid_cnt0", count_o, 0);
    checkOutput("mid_data", bus.out_data_o, 0);
    tick();
    rst_i = 1'b1;
    bus.out_ready_i = 1'b1;
    tick();
    checkOutput("post_valid", bus.out_valid_o, 0);
    pulse(3, 32'h3F3);
    applyStimulus();
    checkOutput("post_lat", bus.out_valid_o, 0);
    tick();
    checkHead("post", 32'h3F3, 3);
    tick();
    checkOutput("post_empty", bus.out_valid_o, 0);
    checkOutput("post_cnt", count_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
